// File: rtl/wb_mtimer_pkg.sv
// wb_mtimer_pkg: register word offsets, CTRL bit indices and reset constants for wb_mtimer.
package wb_mtimer_pkg;
  localparam int ADR_MTIME_LO    = 0;
  localparam int ADR_MTIME_HI    = 1;
  localparam int ADR_MTIMECMP_LO = 2;
  localparam int ADR_MTIMECMP_HI = 3;
  localparam int ADR_CTRL        = 4;
  localparam int ADR_PRESC       = 5;
  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
    for (int b = 0; b < 4; b++) bmerge[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
  endfunction
endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: 16-bit reloading down-counter; ticks when it reaches zero while enabled.
module mtimer_prescaler (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_presc,
  output logic        o_tick
);
  logic [15:0] cnt_q, cnt_d;

  always_comb cnt_d = i_load ? i_presc : !i_en ? cnt_q : (cnt_q == 16'd0) ? i_presc : cnt_q - 16'd1;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;

  assign o_tick = i_en && (cnt_q == 16'd0);
endmodule

// File: rtl/wb_mtimer.sv
// wb_mtimer: Wishbone machine timer (64-bit mtime/mtimecmp, level IRQ).
// Define MTIMER_PRESCALER_EN to add the PRESC register and tick prescaler.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_dev_sel,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_we,
  input  logic [3:0]            i_wb_sel,
  input  logic [ADDR_WIDTH-1:0] i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  output logic [31:0]           o_wb_dat,
  output logic                  o_wb_ack,
  output logic                  o_irq
);
  logic        access, wr, rd, inc, tick, ack_q, irq_q, irq_d;
  logic [5:0]  hit;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_val;
  logic [31:0] shadow_q, shadow_d, rdata, dat_q;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;

  assign access = i_dev_sel & i_wb_cyc & ~ack_q;
  assign wr     = access & i_wb_we;
  assign rd     = access & ~i_wb_we;
  assign inc    = ctrl_q[CTRL_EN] & tick;

  always_comb for (int k = 0; k < 6; k++) hit[k] = (i_wb_adr == ADDR_WIDTH'(k));

`ifdef MTIMER_PRESCALER_EN
  logic [15:0] presc_q, presc_d;
  logic        presc_wr;

  assign presc_wr  = wr & hit[ADR_PRESC];
  assign presc_d   = presc_wr ? {i_wb_sel[1] ? i_wb_dat[15:8] : presc_q[15:8],
                                 i_wb_sel[0] ? i_wb_dat[7:0]  : presc_q[7:0]} : presc_q;
  assign presc_val = presc_q;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) presc_q <= '0;
    else presc_q <= presc_d;

  mtimer_prescaler u_presc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (ctrl_q[CTRL_EN]),
    .i_load    (presc_wr),
    .i_presc   (presc_d),
    .o_tick    (tick)
  );
`else
  assign tick      = 1'b1;
  assign presc_val = '0;
`endif

  // Bus writes to either mtime half win over the tick; the untouched half gets no carry.
  always_comb begin
    mtime_d  = (wr & hit[ADR_MTIME_LO]) ? {mtime_q[63:32], bmerge(mtime_q[31:0], i_wb_dat, i_wb_sel)}
             : (wr & hit[ADR_MTIME_HI]) ? {bmerge(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]}
             : inc ? mtime_q + 64'd1 : mtime_q;
    cmp_d    = (wr & hit[ADR_MTIMECMP_LO]) ? {cmp_q[63:32], bmerge(cmp_q[31:0], i_wb_dat, i_wb_sel)}
             : (wr & hit[ADR_MTIMECMP_HI]) ? {bmerge(cmp_q[63:32], i_wb_dat, i_wb_sel), cmp_q[31:0]}
             : cmp_q;
    ctrl_d   = (wr & hit[ADR_CTRL] & i_wb_sel[0]) ? i_wb_dat[1:0] : ctrl_q;
    shadow_d = (rd & hit[ADR_MTIME_LO]) ? mtime_q[63:32] : shadow_q;
    irq_d    = ctrl_d[CTRL_IRQ_EN] & (mtime_d >= cmp_d);
    rdata    = hit[ADR_MTIME_LO]    ? mtime_q[31:0]
             : hit[ADR_MTIME_HI]    ? shadow_q
             : hit[ADR_MTIMECMP_LO] ? cmp_q[31:0]
             : hit[ADR_MTIMECMP_HI] ? cmp_q[63:32]
             : hit[ADR_CTRL]        ? {30'd0, ctrl_q}
             : hit[ADR_PRESC]       ? {16'd0, presc_val}
             : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      mtime_q  <= '0;
      cmp_q    <= MTIMECMP_RST;
      ctrl_q   <= '0;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      shadow_q <= shadow_d;
      ack_q    <= access;
      dat_q    <= rd ? rdata : '0;
      irq_q    <= irq_d;
    end

  assign o_wb_ack = ack_q;
  assign o_wb_dat = dat_q;
  assign o_irq    = irq_q;
endmodule
